tft_sprite_renderer: RTL

//  Pixel-colour stage downstream of the 800x480 timing generator. Consumes the

---
 rtl/tft_pkg.sv | 31 +++
 rtl/tft_bounce_axis.sv | 58 +++++
 rtl/tft_sprite_renderer.sv | 116 +++++++++++
 3 files changed

// File: rtl/tft_pkg.sv
// rtl/tft_pkg.sv - shared types, panel constants and RGB565 helpers for the TFT sprite renderer
package tft_pkg;

    typedef logic [15:0] rgb565_t;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_e;

    localparam int TFT_H_RES = 800;
    localparam int TFT_V_RES = 480;

    localparam rgb565_t TFT_BLACK        = 16'h0000;
    localparam rgb565_t TFT_BG_COLOR     = 16'h0010;
    localparam rgb565_t TFT_SPR_COLOR    = 16'hF800;
    localparam rgb565_t TFT_BORDER_COLOR = 16'hFFFF;

    function automatic logic [4:0] rgb565_r(input rgb565_t c);
        return c[15:11];
    endfunction

    function automatic logic [5:0] rgb565_g(input rgb565_t c);
        return c[10:5];
    endfunction

    function automatic logic [4:0] rgb565_b(input rgb565_t c);
        return c[4:0];
    endfunction

endpackage

// File: rtl/tft_bounce_axis.sv
// rtl/tft_bounce_axis.sv - one-axis sprite position with FWD/REV bounce, stepping once per frame tick
module tft_bounce_axis
    import tft_pkg::*;
#(
    parameter int RES      = 800,
    parameter int SPR_SIZE = 64,
    parameter int SPEED    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tick,
    output logic [11:0] o_pos
);

    localparam logic [12:0] MAX_POS = 13'(RES - SPR_SIZE);
    localparam logic [12:0] STEP    = 13'(SPEED);

    dir_e        state_q, state_d;
    logic [11:0] pos_q, pos_d;
    logic [12:0] pos_w;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= DIR_FWD;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
        end
    end

    // Clamp onto the edge on the same tick that flips direction.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        pos_w   = {1'b0, pos_q};
        if (i_tick) begin
            if (state_q == DIR_FWD) begin
                if (pos_w + STEP >= MAX_POS) begin
                    pos_d   = MAX_POS[11:0];
                    state_d = DIR_REV;
                end else begin
                    pos_d = pos_q + STEP[11:0];
                end
            end else begin
                if (pos_w <= STEP) begin
                    pos_d   = '0;
                    state_d = DIR_FWD;
                end else begin
                    pos_d = pos_q - STEP[11:0];
                end
            end
        end
    end

    assign o_pos = pos_q;

endmodule

// File: rtl/tft_sprite_renderer.sv
// rtl/tft_sprite_renderer.sv - two-strobe colour pipeline drawing a bouncing square over a solid background
// Optional white 1-pixel sprite border when TFT_SPRITE_BORDER_EN is defined.
module tft_sprite_renderer
    import tft_pkg::*;
#(
    parameter int      H_RES     = TFT_H_RES,
    parameter int      V_RES     = TFT_V_RES,
    parameter int      SPR_SIZE  = 64,
    parameter int      SPEED     = 2,
    parameter rgb565_t BG_COLOR  = TFT_BG_COLOR,
    parameter rgb565_t SPR_COLOR = TFT_SPR_COLOR
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic [11:0] i_x,
    input  logic [8:0]  i_y,
    output logic        o_hs,
    output logic        o_vs,
    output logic [4:0]  o_r,
    output logic [5:0]  o_g,
    output logic [4:0]  o_b
);

    logic [11:0] pos_x, pos_y;
    logic        frame_tick;

    // First pixel of the first blanking line: the sprite moves only here.
    assign frame_tick = i_pix_stb && (i_x == 12'd0) && (i_y == 9'(V_RES));

    tft_bounce_axis #(.RES(H_RES), .SPR_SIZE(SPR_SIZE), .SPEED(SPEED)) u_axis_x (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_tick (frame_tick),
        .o_pos  (pos_x)
    );

    tft_bounce_axis #(.RES(V_RES), .SPR_SIZE(SPR_SIZE), .SPEED(SPEED)) u_axis_y (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_tick (frame_tick),
        .o_pos  (pos_y)
    );

    logic [12:0] x_w, y_w, px_w, py_w;
    logic        active_d, in_spr_d;
    logic        active_q, in_spr_q, hs1_q, vs1_q;
    rgb565_t     rgb_d, rgb_q;
    logic        hs2_q, vs2_q;

    assign x_w  = {1'b0, i_x};
    assign y_w  = {4'b0, i_y};
    assign px_w = {1'b0, pos_x};
    assign py_w = {1'b0, pos_y};

    assign active_d = (x_w < 13'(H_RES)) && (y_w < 13'(V_RES));
    assign in_spr_d = (x_w >= px_w) && (x_w < px_w + 13'(SPR_SIZE)) &&
                      (y_w >= py_w) && (y_w < py_w + 13'(SPR_SIZE));

`ifdef TFT_SPRITE_BORDER_EN
    logic ring_d, ring_q;

    assign ring_d = (x_w == px_w) || (x_w == px_w + 13'(SPR_SIZE - 1)) ||
                    (y_w == py_w) || (y_w == py_w + 13'(SPR_SIZE - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ring_q <= 1'b0;
        end else if (i_pix_stb) begin
            ring_q <= ring_d;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            active_q <= 1'b0;
            in_spr_q <= 1'b0;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            rgb_q    <= TFT_BLACK;
            hs2_q    <= 1'b1;
            vs2_q    <= 1'b1;
        end else if (i_pix_stb) begin
            active_q <= active_d;
            in_spr_q <= in_spr_d;
            hs1_q    <= i_hs;
            vs1_q    <= i_vs;
            rgb_q    <= rgb_d;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
        end
    end

    always_comb begin
        rgb_d = BG_COLOR;
        if (!active_q) begin
            rgb_d = TFT_BLACK;
        end else if (in_spr_q) begin
`ifdef TFT_SPRITE_BORDER_EN
            rgb_d = ring_q ? TFT_BORDER_COLOR : SPR_COLOR;
`else
            rgb_d = SPR_COLOR;
`endif
        end
    end

    assign o_hs = hs2_q;
    assign o_vs = vs2_q;
    assign o_r  = rgb565_r(rgb_q);
    assign o_g  = rgb565_g(rgb_q);
    assign o_b  = rgb565_b(rgb_q);

endmodule
